mp_mem: RTL and testbench



---
 rtl/mp_mem_if.sv | 25 ++
 rtl/mp_mem.sv | 110 +++++++++++
 tb/tb_mp_mem.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mp_mem_if.sv
// Request/response bundle for the N-port memory: flat per-port packing,
// port p at [p*W +: W].
interface mp_mem_if #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4
);
    logic [NUM_PORTS-1:0]        valid;
    logic [NUM_PORTS-1:0]        op;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wr_data;
    logic [NUM_PORTS-1:0]        ready;
    logic [NUM_PORTS*DATA_W-1:0] rd_data;
    logic [NUM_PORTS-1:0]        rd_valid;
    logic [NUM_PORTS-1:0]        err;

    modport master (
        output valid, op, addr, wr_data,
        input  ready, rd_data, rd_valid, err
    );
    modport slave (
        input  valid, op, addr, wr_data,
        output ready, rd_data, rd_valid, err
    );
endinterface

// File: rtl/mp_mem.sv
// N-port synchronous memory with round-robin resolution of same-address
// conflicts, out-of-range error pulses and a saturating collision counter.
module mp_mem_lane #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 4,
    parameter int RW        = 1,
    parameter int PORT      = 0
) (
    input  logic                             rstn,
    input  logic [RW-1:0]                    rr_ptr,
    input  logic [NUM_PORTS-1:0]             valid,
    input  logic [NUM_PORTS-1:0]             op,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr,
    output logic                             ready
);
    int   rp, rq;
    logic blk;

    // Rank 0 is the port at rr_ptr; any conflicting port of lower rank blocks us,
    // whether or not that port is itself granted.
    always_comb begin
        blk = 1'b0;
        rq  = 0;
        rp  = (PORT + NUM_PORTS - int'(rr_ptr)) % NUM_PORTS;
        for (int q = 0; q < NUM_PORTS; q++) begin
            if (q != PORT) begin
                rq = (q + NUM_PORTS - int'(rr_ptr)) % NUM_PORTS;
                if (valid[q] && addr[q] == addr[PORT] && (op[q] || op[PORT]) && rq < rp)
                    blk = 1'b1;
            end
        end
        ready = rstn & valid[PORT] & ~blk;
    end
endmodule

module mp_mem #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    mp_mem_if.slave          bus,
    output logic [CNT_W-1:0] collision_cnt
);
    localparam int RW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NUM_PORTS-1:0][ADDR_W-1:0] a;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wd;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdd;
    logic [NUM_PORTS-1:0][IW-1:0]     idx;
    logic [NUM_PORTS-1:0]             rdy, xfer, inr, rdv, er;
    logic [RW-1:0]                    rr_ptr;
    logic [DATA_W-1:0]                mem [DEPTH];
    logic                             deny;

    assign a            = bus.addr;
    assign wd           = bus.wr_data;
    assign bus.ready    = rdy;
    assign bus.rd_data  = rdd;
    assign bus.rd_valid = rdv;
    assign bus.err      = er;
    assign xfer         = bus.valid & rdy;
    assign deny         = |(bus.valid & ~rdy);

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        mp_mem_lane #(.NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .RW(RW), .PORT(g)) u_lane (
            .rstn   (rstn),
            .rr_ptr (rr_ptr),
            .valid  (bus.valid),
            .op     (bus.op),
            .addr   (a),
            .ready  (rdy[g])
        );
        if (DEPTH >= 2**ADDR_W) begin : g_full
            assign inr[g] = 1'b1;
        end else begin : g_part
            assign inr[g] = a[g] < ADDR_W'(DEPTH);
        end
        assign idx[g] = a[g][IW-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdd           <= '0;
            rdv           <= '0;
            er            <= '0;
            collision_cnt <= '0;
            rr_ptr        <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rdv[p] <= xfer[p] & ~bus.op[p];
                er[p]  <= xfer[p] & ~inr[p];
                // Reads see pre-edge contents; out-of-range reads return zero.
                if (xfer[p] && !bus.op[p])
                    rdd[p] <= inr[p] ? mem[idx[p]] : '0;
                if (xfer[p] && bus.op[p] && inr[p])
                    mem[idx[p]] <= wd[p];
            end
            if (deny) begin
                rr_ptr <= (rr_ptr == RW'(NUM_PORTS - 1)) ? '0 : rr_ptr + 1'b1;
                if (!(&collision_cnt)) collision_cnt <= collision_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mp_mem.sv
// Directed bench for mp_mem: 4-port/DEPTH=12 instance with a read scoreboard,
// plus a 2-port CNT_W=2 instance for counter saturation.
module tb_mp_mem;
    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int         port;
        bit         is_rd;
        bit         er;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [16];

    mp_mem_if #(.NUM_PORTS(4), .DATA_W(8), .ADDR_W(4)) m ();
    mp_mem_if #(.NUM_PORTS(2), .DATA_W(8), .ADDR_W(4)) s ();

    mp_mem #(.NUM_PORTS(4), .DATA_W(8), .ADDR_W(4), .DEPTH(12), .CNT_W(16)) u0 (
        .clk(clk), .rstn(rstn), .bus(m.slave), .collision_cnt(cnt0));
    mp_mem #(.NUM_PORTS(2), .DATA_W(8), .ADDR_W(4), .DEPTH(16), .CNT_W(2)) u1 (
        .clk(clk), .rstn(rstn), .bus(s.slave), .collision_cnt(cnt1));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(int p, logic [3:0] ad, logic [7:0] d);
        m.valid[p] = 1'b1; m.op[p] = 1'b1;
        m.addr[p*4 +: 4] = ad; m.wr_data[p*8 +: 8] = d;
    endtask

    task automatic rd(int p, logic [3:0] ad);
        m.valid[p] = 1'b1; m.op[p] = 1'b0;
        m.addr[p*4 +: 4] = ad; m.wr_data[p*8 +: 8] = 8'h00;
    endtask

    task automatic clr(int p);
        m.valid[p] = 1'b0;
    endtask

    task automatic clr_all();
        m.valid = '0;
    endtask

    task automatic rdy_chk(string tag, logic [3:0] e);
        #1;
        chk(tag, 32'(m.ready), 32'(e));
    endtask

    // Accepted requests push their expected next-cycle response; the model
    // memory supplies read data from pre-edge contents.
    task automatic tick();
        exp_t       e;
        logic [3:0] ad;
        logic [3:0] mask;
        #1;
        for (int p = 0; p < 4; p++) begin
            if (m.valid[p] && m.ready[p]) begin
                ad      = m.addr[p*4 +: 4];
                e.port  = p;
                e.is_rd = !m.op[p];
                e.er    = (ad >= 4'd12);
                e.data  = (e.is_rd && !e.er) ? mdl[ad] : 8'h00;
                sb.push_back(e);
            end
        end
        for (int p = 0; p < 4; p++) begin
            ad = m.addr[p*4 +: 4];
            if (m.valid[p] && m.ready[p] && m.op[p] && ad < 4'd12)
                mdl[ad] = m.wr_data[p*8 +: 8];
        end
        @(posedge clk);
        #1;
        mask = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mask[e.port] = 1'b1;
            chk($sformatf("rd_valid[%0d]", e.port), 32'(m.rd_valid[e.port]), 32'(e.is_rd));
            chk($sformatf("err[%0d]", e.port), 32'(m.err[e.port]), 32'(e.er));
            if (e.is_rd)
                chk($sformatf("rd_data[%0d]", e.port), 32'(m.rd_data[e.port*8 +: 8]), 32'(e.data));
        end
        chk("spurious_rd_valid", 32'(m.rd_valid & ~mask), 32'd0);
        chk("spurious_err", 32'(m.err & ~mask), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        rstn = 1'b0;
        m.valid = '1; m.op = '0; m.addr = '0; m.wr_data = '0;
        s.valid = '1; s.op = '0; s.addr = '0; s.wr_data = '0;
        #2;
        chk("rst_ready0", 32'(m.ready), 32'd0);
        chk("rst_ready1", 32'(s.ready), 32'd0);
        chk("rst_rd_valid", 32'(m.rd_valid), 32'd0);
        chk("rst_err", 32'(m.err), 32'd0);
        chk("rst_rd_data", m.rd_data, 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        clr_all(); s.valid = '0;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;

        // write then read-after-write on another port
        wr(0, 4'd3, 8'hA5);
        rdy_chk("t1_wr_ready", 4'b0001);
        tick(); clr_all();
        rd(1, 4'd3);
        rdy_chk("t1_rd_ready", 4'b0010);
        tick(); clr_all();
        chk("t1_cnt", 32'(cnt0), 32'd0);

        // two readers above a writer at the same address
        rd(0, 4'd7); rd(1, 4'd7); wr(2, 4'd7, 8'h55);
        rdy_chk("t3_ready", 4'b0011);
        tick(); clr(0); clr(1);
        rdy_chk("t3_ready_retry", 4'b0100);
        tick(); clr_all();
        chk("t3_cnt", 32'(cnt0), 32'd1);
        rd(0, 4'd7);
        rdy_chk("t3_readback_ready", 4'b0001);
        tick(); clr_all();

        // out-of-range accesses
        wr(0, 4'd13, 8'h77); rd(1, 4'd14);
        rdy_chk("t4_ready", 4'b0011);
        tick(); clr_all();
        chk("t4_cnt", 32'(cnt0), 32'd1);
        rd(0, 4'd1); rd(1, 4'd5); rd(2, 4'd9); rd(3, 4'd3);
        rdy_chk("t4_readback_ready", 4'b1111);
        tick(); clr_all();

        // reset while a read is in flight
        rd(0, 4'd3);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("t5_rd_valid", 32'(m.rd_valid), 32'd0);
        chk("t5_rd_data", m.rd_data, 32'd0);
        chk("t5_cnt", 32'(cnt0), 32'd0);
        clr_all();
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        sb.delete();
        for (int i = 0; i < 12; i += 4) begin
            for (int p = 0; p < 4; p++) rd(p, 4'(i + p));
            rdy_chk($sformatf("t5_sweep_ready_%0d", i), 4'b1111);
            tick(); clr_all();
        end

        // four writers at one address, held until accepted
        for (int p = 0; p < 4; p++) wr(p, 4'd5, 8'(8'h10 + p));
        for (int k = 0; k < 4; k++) begin
            rdy_chk($sformatf("t2_grant_%0d", k), 4'(1 << k));
            tick(); clr(k);
        end
        chk("t2_cnt", 32'(cnt0), 32'd3);
        rd(0, 4'd5);
        rdy_chk("t2_readback_ready", 4'b0001);
        tick(); clr_all();
        chk("t2_model_final", 32'(mdl[5]), 32'h13);

        // saturation on the 2-bit counter instance
        s.valid = 2'b11; s.op = 2'b11; s.addr = '0; s.wr_data = 16'h2211;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t6_ready_%0d", k), 32'(s.ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk); #1;
            if (k == 1) chk("t6_cnt_2", 32'(cnt1), 32'd2);
        end
        chk("t6_cnt_sat", 32'(cnt1), 32'd3);
        s.valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
